mc_datapath: RTL and testbench
==============================

// Module: mc_datapath
// PURPOSE
//  Multi-cycle RV32I datapath: next-generation datapath with an internal phase sequencer.
//  Talks to external instruction and data memories over variable-latency req/ack handshakes.
//  Decoded control comes from the existing control unit (fields out, control in).
//  Reuses regfile, alu, imm_decoder, branch_unit, adder and mux primitives.
// PARAMETERS
//  AddressWidth  10  PC and memory byte-address width; PC wraps modulo 2**AddressWidth
//  ResetPc       0   PC value loaded on reset; bits [1:0] must be 0
//  RetireCntW    32  retire-counter width; used only when MC_RETIRE_CNT_EN is defined
// PORTS
//  clk_i            in   1             single clock
//  rst_i            in   1             reset: synchronous, active-high
//  jal_i/jalr_i/branch_i in 1          control-unit branch class
//  regf_wr_en_i     in   1             regfile write enable (sampled in WB)
//  regf_wr_src_i    in   2             0=ALU 1=load data 2=PC+4 3=imm
//  mem_r_en_i/mem_wr_en_i in 1         load/store instruction
//  alu_src2_sel_i   in   1             0=rs2 1=imm
//  alu_op_i         in   4             ALU operation
//  op_code_o/funct3_o/funct7_o out 7/3/7  fields of latched IR
//  imem_req_o/imem_addr_o out 1/AddressWidth  fetch request; addr = PC
//  imem_ack_i/imem_rdata_i in 1/32     fetch done; rdata valid with ack
//  dmem_req_o/dmem_we_o out 1/1        data request; we=1 store
//  dmem_addr_o/dmem_wdata_o out AddressWidth/32  ALU result / rs2
//  dmem_funct3_o    out  3             access size/sign
//  dmem_ack_i/dmem_rdata_i in 1/32     data done; rdata valid with ack on loads
//  instr_retired_o  out  1             1-cycle pulse per completed instruction
//  retire_cnt_o     out  RetireCntW    only with MC_RETIRE_CNT_EN
// BEHAVIOUR
//  Reset: state=FETCH, PC=ResetPc, IR=32'h0000_0013 (NOP), A/B/ALUOut/MDR=0; all req/we/retire outputs 0.
//  Reset mid-transaction: req drops the next cycle; a late ack arriving in FETCH before the new req is ignored.
//  FETCH: imem_req_o=1 with PC held stable until imem_ack_i; IR<=rdata on ack -> DECODE.
//    Ack may arrive in the first cycle of req (1-cycle fetch).
//  DECODE: A<=rs1 data, B<=rs2 data, IMM latched -> EXECUTE.
//  EXECUTE: ALUOut<=alu(A, src2); branch_unit evaluated from ALUOut[0].
//    mem_r_en_i|mem_wr_en_i -> MEM; else -> WB.
//  MEM: dmem_req_o=1, with addr/wdata/we/funct3 held stable until dmem_ack_i; MDR<=rdata on ack -> WB.
//    Both enables set: treat as store.
//  WB: regfile write when regf_wr_en_i (x0 writes discarded by regfile).
//    PC<=target if pc_src_sel else PC+4; bit[1:0] of next PC forced 0.
//    instr_retired_o=1 this cycle -> FETCH.
//  Latency: ALU/branch/jump = fetch_wait+1+3 cycles; load/store = fetch_wait+mem_wait+1+4.
//  Only one of imem_req_o/dmem_req_o is ever high; a req, once high, never drops before ack (except reset).
//  PC+4 at 2**AddressWidth-4 wraps to 0. JALR target = (rs1+imm)&~1, then bits[1:0] forced 0.
// CONFIGURATION
//  MC_RETIRE_CNT_EN defined: retire_cnt_o increments in every WB cycle, wraps at 2**RetireCntW, and is 0 on reset.
//  Not defined: no counter register; the retire_cnt_o port is absent.
// STRUCTURE
//  mc_datapath_pkg holds:
//    - state_e {FETCH, DECODE, EXECUTE, MEM, WB}
//    - wr_src_e localparams (WR_SRC_ALU/MEM/PC4/IMM)
//    - NOP_INSTR constant
//  Sub-module mc_sequencer: the phase FSM (state, req generation, IR/A/B/ALUOut/MDR load strobes).
//  Datapath registers and muxes stay in mc_datapath.
// TESTING
//  1. Reset with ResetPc=0, imem ack same cycle, addi x1,x0,5 -> x1=5, retire pulse on cycle 4, PC=4.
//  2. imem ack delayed 3 cycles -> imem_addr_o stable and req held for 3 cycles; no other state advance.
//  3. sw x1,8(x0) then lw x2,8(x0), dmem ack delayed 2 cycles:
//     - store: dmem_we_o=1, addr=8, wdata=5
//     - load: x2=5, dmem_req_o low in all non-MEM cycles
//  4. beq x0,x0,-8 at PC=16 -> next PC=8; bne x0,x0 at PC=16 -> next PC=20.
//  5. jal x1,+12 at PC=2**AddressWidth-4 -> x1=0 (wrapped PC+4); jalr to odd address 0x13 -> PC=0x10.
//  6. rst_i asserted during a MEM wait -> dmem_req_o 0 next cycle, PC=ResetPc, regfile unchanged.
//     Retire counter (MC_RETIRE_CNT_EN) =0, then 3 after three instructions.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// rtl/mc_datapath_pkg.sv - shared types, constants and ALU/immediate helpers for mc_datapath
package mc_datapath_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_e;

    localparam logic [1:0] WR_SRC_ALU = 2'd0;
    localparam logic [1:0] WR_SRC_MEM = 2'd1;
    localparam logic [1:0] WR_SRC_PC4 = 2'd2;
    localparam logic [1:0] WR_SRC_IMM = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Compare ops return their result in bit 0 so the branch unit only looks at ALUOut[0]
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  alu = a + b;
            ALU_SUB:  alu = a - b;
            ALU_SLL:  alu = a << b[4:0];
            ALU_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: alu = {31'b0, a < b};
            ALU_XOR:  alu = a ^ b;
            ALU_SRL:  alu = a >> b[4:0];
            ALU_SRA:  alu = $signed(a) >>> b[4:0];
            ALU_OR:   alu = a | b;
            ALU_AND:  alu = a & b;
            ALU_EQ:   alu = {31'b0, a == b};
            ALU_NE:   alu = {31'b0, a != b};
            ALU_GE:   alu = {31'b0, $signed(a) >= $signed(b)};
            ALU_GEU:  alu = {31'b0, a >= b};
            default:  alu = 32'b0;
        endcase
    endfunction

    function automatic logic [31:0] imm_decode(input logic [31:0] ir);
        case (ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: imm_decode = {{20{ir[31]}}, ir[31:20]};
            7'b0100011: imm_decode = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm_decode = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b0110111, 7'b0010111: imm_decode = {ir[31:12], 12'b0};
            7'b1101111: imm_decode = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_decode = 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - phase FSM: memory request generation and datapath register load strobes
module mc_sequencer
    import mc_datapath_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic imem_ack_i,
    input  logic dmem_ack_i,
    input  logic mem_access_i,
    input  logic store_i,
    output logic imem_req_o,
    output logic dmem_req_o,
    output logic ir_load_o,
    output logic ab_load_o,
    output logic alu_load_o,
    output logic mdr_load_o,
    output logic wb_o
);

    state_e state, state_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Everything is held quiet while reset is asserted so a late ack cannot advance the FSM
    always_comb begin
        state_next = state;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        ir_load_o  = 1'b0;
        ab_load_o  = 1'b0;
        alu_load_o = 1'b0;
        mdr_load_o = 1'b0;
        wb_o       = 1'b0;
        if (!rst_i) begin
            case (state)
                FETCH: begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        ir_load_o  = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    ab_load_o  = 1'b1;
                    state_next = EXECUTE;
                end
                EXECUTE: begin
                    alu_load_o = 1'b1;
                    state_next = mem_access_i ? MEM : WB;
                end
                MEM: begin
                    dmem_req_o = 1'b1;
                    if (dmem_ack_i) begin
                        mdr_load_o = !store_i;
                        state_next = WB;
                    end
                end
                WB: begin
                    wb_o       = 1'b1;
                    state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle RV32I datapath with req/ack instruction and data memories
// Optional retire counter port and register enabled by defining MC_RETIRE_CNT_EN.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int AddressWidth = 10,
    parameter logic [AddressWidth-1:0] ResetPc = '0,
    parameter int RetireCntW = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    jal_i,
    input  logic                    jalr_i,
    input  logic                    branch_i,
    input  logic                    regf_wr_en_i,
    input  logic [1:0]              regf_wr_src_i,
    input  logic                    mem_r_en_i,
    input  logic                    mem_wr_en_i,
    input  logic                    alu_src2_sel_i,
    input  logic [3:0]              alu_op_i,
    output logic [6:0]              op_code_o,
    output logic [2:0]              funct3_o,
    output logic [6:0]              funct7_o,
    output logic                    imem_req_o,
    output logic [AddressWidth-1:0] imem_addr_o,
    input  logic                    imem_ack_i,
    input  logic [31:0]             imem_rdata_i,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [AddressWidth-1:0] dmem_addr_o,
    output logic [31:0]             dmem_wdata_o,
    output logic [2:0]              dmem_funct3_o,
    input  logic                    dmem_ack_i,
    input  logic [31:0]             dmem_rdata_i,
    output logic                    instr_retired_o
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [RetireCntW-1:0]   retire_cnt_o
`endif
);

    logic ir_load, ab_load, alu_load, mdr_load, wb;

    mc_sequencer u_sequencer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_ack_i   (imem_ack_i),
        .dmem_ack_i   (dmem_ack_i),
        .mem_access_i (mem_r_en_i | mem_wr_en_i),
        .store_i      (mem_wr_en_i),
        .imem_req_o   (imem_req_o),
        .dmem_req_o   (dmem_req_o),
        .ir_load_o    (ir_load),
        .ab_load_o    (ab_load),
        .alu_load_o   (alu_load),
        .mdr_load_o   (mdr_load),
        .wb_o         (wb)
    );

    logic [AddressWidth-1:0] pc, pc_plus4, target, pc_next;
    logic [31:0] ir, a, b, alu_out, mdr, imm;
    logic [31:0] regs [32];
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, src2, wr_data;
    logic        pc_src_sel;

    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign rd       = ir[11:7];
    assign rs1_data = (rs1 == 5'd0) ? 32'b0 : regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'b0 : regs[rs2];
    assign src2     = alu_src2_sel_i ? imm : b;

    // PC arithmetic is done at AddressWidth so PC+4 and targets wrap naturally
    assign pc_plus4   = pc + AddressWidth'(4);
    assign target     = (jalr_i ? a[AddressWidth-1:0] : pc) + imm[AddressWidth-1:0];
    assign pc_src_sel = jal_i | jalr_i | (branch_i & alu_out[0]);
    assign pc_next    = pc_src_sel ? {target[AddressWidth-1:2], 2'b00}
                                   : {pc_plus4[AddressWidth-1:2], 2'b00};

    always_comb begin
        wr_data = alu_out;
        case (regf_wr_src_i)
            WR_SRC_ALU: wr_data = alu_out;
            WR_SRC_MEM: wr_data = mdr;
            WR_SRC_PC4: wr_data = 32'(pc_plus4);
            WR_SRC_IMM: wr_data = imm;
            default:    wr_data = alu_out;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc      <= ResetPc;
            ir      <= NOP_INSTR;
            a       <= 32'b0;
            b       <= 32'b0;
            imm     <= 32'b0;
            alu_out <= 32'b0;
            mdr     <= 32'b0;
        end else begin
            if (ir_load) ir <= imem_rdata_i;
            if (ab_load) begin
                a   <= rs1_data;
                b   <= rs2_data;
                imm <= imm_decode(ir);
            end
            if (alu_load) alu_out <= alu(alu_op_i, a, src2);
            if (mdr_load) mdr <= dmem_rdata_i;
            if (wb) pc <= pc_next;
        end
    end

    // Regfile has no reset so a mid-instruction reset leaves architectural registers intact
    always_ff @(posedge clk_i) begin
        if (wb && regf_wr_en_i && rd != 5'd0) regs[rd] <= wr_data;
    end

`ifdef MC_RETIRE_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retire_cnt_o <= '0;
        end else if (wb) begin
            retire_cnt_o <= retire_cnt_o + 1'b1;
        end
    end
`endif

    assign op_code_o       = ir[6:0];
    assign funct3_o        = ir[14:12];
    assign funct7_o        = ir[31:25];
    assign imem_addr_o     = pc;
    assign dmem_we_o       = dmem_req_o & mem_wr_en_i;
    assign dmem_addr_o     = alu_out[AddressWidth-1:0];
    assign dmem_wdata_o    = b;
    assign dmem_funct3_o   = ir[14:12];
    assign instr_retired_o = wb;

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - directed self-checking bench for mc_datapath with a small control unit model
module tb_mc_datapath;
    import mc_datapath_pkg::*;

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        jal_i, jalr_i, branch_i, regf_wr_en_i, mem_r_en_i, mem_wr_en_i, alu_src2_sel_i;
    logic [1:0]  regf_wr_src_i;
    logic [3:0]  alu_op_i;
    logic [6:0]  op_code_o, funct7_o;
    logic [2:0]  funct3_o, dmem_funct3_o;
    logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i, instr_retired_o;
    logic [9:0]  imem_addr_o, dmem_addr_o;
    logic [31:0] imem_rdata_i, dmem_wdata_o, dmem_rdata_i;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retire_cnt_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    mc_datapath dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .jal_i           (jal_i),
        .jalr_i          (jalr_i),
        .branch_i        (branch_i),
        .regf_wr_en_i    (regf_wr_en_i),
        .regf_wr_src_i   (regf_wr_src_i),
        .mem_r_en_i      (mem_r_en_i),
        .mem_wr_en_i     (mem_wr_en_i),
        .alu_src2_sel_i  (alu_src2_sel_i),
        .alu_op_i        (alu_op_i),
        .op_code_o       (op_code_o),
        .funct3_o        (funct3_o),
        .funct7_o        (funct7_o),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_funct3_o   (dmem_funct3_o),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .instr_retired_o (instr_retired_o)
`ifdef MC_RETIRE_CNT_EN
        ,
        .retire_cnt_o    (retire_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Minimal control unit covering the instructions used below
    always_comb begin
        jal_i = 1'b0; jalr_i = 1'b0; branch_i = 1'b0; regf_wr_en_i = 1'b0;
        regf_wr_src_i = WR_SRC_ALU; mem_r_en_i = 1'b0; mem_wr_en_i = 1'b0;
        alu_src2_sel_i = 1'b0; alu_op_i = ALU_ADD;
        case (op_code_o)
            7'h13: begin regf_wr_en_i = 1'b1; alu_src2_sel_i = 1'b1; end
            7'h33: begin regf_wr_en_i = 1'b1; alu_op_i = funct7_o[5] ? ALU_SUB : ALU_ADD; end
            7'h03: begin regf_wr_en_i = 1'b1; regf_wr_src_i = WR_SRC_MEM; mem_r_en_i = 1'b1; alu_src2_sel_i = 1'b1; end
            7'h23: begin mem_wr_en_i = 1'b1; alu_src2_sel_i = 1'b1; end
            7'h63: begin branch_i = 1'b1; alu_op_i = (funct3_o == 3'd1) ? ALU_NE : ALU_EQ; end
            7'h6F: begin jal_i = 1'b1; regf_wr_en_i = 1'b1; regf_wr_src_i = WR_SRC_PC4; end
            7'h67: begin jalr_i = 1'b1; regf_wr_en_i = 1'b1; regf_wr_src_i = WR_SRC_PC4; alu_src2_sel_i = 1'b1; end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_fetch(input logic [9:0] pc, input logic [31:0] instr, input int fwait);
        check_eq("fetch_req", imem_req_o, 1);
        check_eq("fetch_addr", imem_addr_o, pc);
        check_eq("fetch_dmem_quiet", dmem_req_o, 0);
        check_eq("fetch_no_retire", instr_retired_o, 0);
        for (int i = 0; i < fwait; i++) begin
            @(negedge clk);
            check_eq("fetch_req_held", imem_req_o, 1);
            check_eq("fetch_addr_stable", imem_addr_o, pc);
            check_eq("fetch_wait_dmem_quiet", dmem_req_o, 0);
            check_eq("fetch_wait_no_retire", instr_retired_o, 0);
        end
        imem_ack_i = 1'b1;
        imem_rdata_i = instr;
        @(negedge clk);
        imem_ack_i = 1'b0;
        imem_rdata_i = 32'h0;
    endtask

    task automatic quiet_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("mid_imem_req", imem_req_o, 0);
            check_eq("mid_dmem_req", dmem_req_o, 0);
            check_eq("mid_retire", instr_retired_o, 0);
            @(negedge clk);
        end
    endtask

    task automatic do_mem(input logic we, input logic [9:0] addr, input logic [31:0] data, input int mwait);
        for (int i = 0; i <= mwait; i++) begin
            check_eq("mem_req", dmem_req_o, 1);
            check_eq("mem_imem_quiet", imem_req_o, 0);
            check_eq("mem_we", dmem_we_o, we);
            check_eq("mem_addr", dmem_addr_o, addr);
            check_eq("mem_funct3", dmem_funct3_o, 3'd2);
            if (we) check_eq("mem_wdata", dmem_wdata_o, data);
            if (i < mwait) @(negedge clk);
        end
        dmem_ack_i = 1'b1;
        dmem_rdata_i = we ? 32'h0 : data;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
    endtask

    task automatic run_instr(input logic [9:0] pc, input logic [31:0] instr, input int fwait,
                             input int kind, input logic [9:0] maddr, input logic [31:0] mdata,
                             input int mwait);
        do_fetch(pc, instr, fwait);
        quiet_cycles(2);
        if (kind != K_ALU) do_mem(kind == K_ST, maddr, mdata, mwait);
        check_eq("wb_retire", instr_retired_o, 1);
        check_eq("wb_imem_quiet", imem_req_o, 0);
        check_eq("wb_dmem_quiet", dmem_req_o, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        check_eq("watchdog", 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        rst_i = 1'b1;
        imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_imem_req", imem_req_o, 0);
        check_eq("rst_dmem_req", dmem_req_o, 0);
        check_eq("rst_dmem_we", dmem_we_o, 0);
        check_eq("rst_retire", instr_retired_o, 0);
        check_eq("rst_pc", imem_addr_o, 10'd0);
        check_eq("rst_ir_nop_opcode", op_code_o, 7'h13);
        check_eq("rst_dmem_addr", dmem_addr_o, 10'd0);
`ifdef MC_RETIRE_CNT_EN
        check_eq("rst_retire_cnt", retire_cnt_o, 0);
`endif
        rst_i = 1'b0;
        #1;
        run_instr(10'd0,    32'h00500093, 0, K_ALU, 10'd0,  32'd0, 0); // addi x1,x0,5
        run_instr(10'd4,    32'h00102423, 3, K_ST,  10'd8,  32'd5, 2); // sw x1,8(x0)
        run_instr(10'd8,    32'h00802103, 0, K_LD,  10'd8,  32'd5, 2); // lw x2,8(x0)
        run_instr(10'd12,   32'h00202623, 0, K_ST,  10'd12, 32'd5, 0); // sw x2,12(x0)
        run_instr(10'd16,   32'hFE000CE3, 0, K_ALU, 10'd0,  32'd0, 0); // beq x0,x0,-8
        run_instr(10'd8,    32'h0080006F, 0, K_ALU, 10'd0,  32'd0, 0); // jal x0,+8
        run_instr(10'd16,   32'h00001463, 0, K_ALU, 10'd0,  32'd0, 0); // bne x0,x0,+8
        run_instr(10'd20,   32'h3E80006F, 0, K_ALU, 10'd0,  32'd0, 0); // jal x0,+1000
        run_instr(10'd1020, 32'h00C000EF, 1, K_ALU, 10'd0,  32'd0, 0); // jal x1,+12
        run_instr(10'd8,    32'h01300067, 0, K_ALU, 10'd0,  32'd0, 0); // jalr x0,0x13(x0)
        run_instr(10'd16,   32'h00102C23, 0, K_ST,  10'd24, 32'd0, 1); // sw x1,24(x0)
`ifdef MC_RETIRE_CNT_EN
        check_eq("retire_cnt_11", retire_cnt_o, 11);
`endif
        // lw x3,4(x0) interrupted by reset while waiting for dmem ack
        do_fetch(10'd20, 32'h00402183, 0);
        quiet_cycles(2);
        check_eq("pre_rst_mem_req", dmem_req_o, 1);
        check_eq("pre_rst_mem_addr", dmem_addr_o, 10'd4);
        @(negedge clk);
        rst_i = 1'b1;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'h00000000;
        @(negedge clk);
        check_eq("rst_mid_dmem_req", dmem_req_o, 0);
        check_eq("rst_mid_imem_req", imem_req_o, 0);
        check_eq("rst_mid_pc", imem_addr_o, 10'd0);
        @(negedge clk);
        check_eq("rst_late_ack_ignored", op_code_o, 7'h13);
`ifdef MC_RETIRE_CNT_EN
        check_eq("rst_mid_retire_cnt", retire_cnt_o, 0);
`endif
        imem_ack_i = 1'b0;
        imem_rdata_i = 32'h0;
        rst_i = 1'b0;
        #1;
        run_instr(10'd0, 32'h00202623, 0, K_ST, 10'd12, 32'd5, 0); // sw x2,12(x0)
        run_instr(10'd4, 32'h00102C23, 0, K_ST, 10'd24, 32'd0, 0); // sw x1,24(x0)
        run_instr(10'd8, 32'h00302E23, 0, K_ST, 10'd28, 32'd0, 0); // sw x3,28(x0)
        check_eq("final_pc", imem_addr_o, 10'd12);
`ifdef MC_RETIRE_CNT_EN
        check_eq("retire_cnt_3", retire_cnt_o, 3);
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
